// File: rtl/instrument_mem_pkg.sv
// Shared types and constants for the instrument dual-port RAM.
package instrument_mem_pkg;

  // CLEAR zero-fills the array after reset; RUN serves both Avalon ports.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_e;

  localparam int COLL_CNT_W = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/instrument_dpram_avalon_if.sv
// One Avalon-MM slave port of the instrument RAM.
interface instrument_dpram_avalon_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/instrument_mem_rd_pipe.sv
// Read-return pipeline for one port: LATENCY stages of valid + data.
// Reset clears every stage so reads in flight at reset never return.
module instrument_mem_rd_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]  dat_q [LATENCY];

  // Shift valid every cycle; data only advances alongside a valid so
  // readdata holds the last returned word between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/instrument_dpram_avalon.sv
// True dual-port instrument RAM with two Avalon-MM slave ports.
// After reset the array is zero-filled through the port-1 write path
// while both ports stall; same-address writes resolve in favour of s1.
//
// state    | meaning
// ST_CLEAR | writing zero to clear_addr_q, both waitrequests high
// ST_RUN   | normal service, no back-pressure
module instrument_dpram_avalon
  import instrument_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instrument_dpram_avalon_if.slave s1,
  instrument_dpram_avalon_if.slave s2,
  output logic [COLL_CNT_W-1:0] collision_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / 8;

  if (!rd_lat_legal(READ_LATENCY)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end

  mem_state_e state_q, state_d;
  logic [ADDR_W:0] clear_addr_q;
  logic clear_en, wait_req, clear_last;

  logic acc_wr1, acc_wr2, acc_rd1, acc_rd2, collide;
  logic              wr1_en, wr2_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic [LANES-1:0]  wr1_be;

  logic [DATA_W-1:0] mem [DEPTH];

  assign clear_last = (clear_addr_q == (ADDR_W+1)'(DEPTH - 1));

  // State register; without clearing the ports come up ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    else          state_q <= state_d;
  end

  // Leave CLEAR on the edge that writes the last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clear_last) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Back-pressure and clear-path enable follow the current state.
  always_comb begin
    clear_en = 1'b0;
    wait_req = 1'b0;
    if (state_q == ST_CLEAR) begin
      clear_en = 1'b1;
      wait_req = 1'b1;
    end
  end

  assign s1.waitrequest = wait_req;
  assign s2.waitrequest = wait_req;

  // Clear address walks 0..DEPTH-1; extra bit keeps the last step from wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      clear_addr_q <= '0;
    else if (clear_en) clear_addr_q <= clear_addr_q + 1'b1;
  end

  assign acc_wr1 = s1.chipselect & s1.write & ~wait_req;
  assign acc_wr2 = s2.chipselect & s2.write & ~wait_req;
  assign acc_rd1 = s1.chipselect & s1.read & ~s1.write & ~wait_req;
  assign acc_rd2 = s2.chipselect & s2.read & ~s2.write & ~wait_req;
  assign collide = acc_wr1 & acc_wr2 & (s1.address == s2.address);

  // Port-1 write path is shared with the zero-fill sequence.
  always_comb begin
    wr1_en   = acc_wr1;
    wr1_addr = s1.address;
    wr1_data = s1.writedata;
    wr1_be   = s1.byteenable;
    if (clear_en) begin
      wr1_en   = 1'b1;
      wr1_addr = clear_addr_q[ADDR_W-1:0];
      wr1_data = '0;
      wr1_be   = '1;
    end
  end

  assign wr2_en = acc_wr2 & ~collide;

  // Byte-lane writes; a colliding s2 write is dropped entirely.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (wr1_en && wr1_be[b])
        mem[wr1_addr][b*8 +: 8] <= wr1_data[b*8 +: 8];
      if (wr2_en && s2.byteenable[b])
        mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
    end
  end

  // Count dropped s2 writes, sticking at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      collision_cnt <= '0;
    else if (collide && (collision_cnt != '1))
      collision_cnt <= collision_cnt + 1'b1;
  end

  // Array is sampled before this edge's writes land, giving old data on
  // read-during-write.
  instrument_mem_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd_pipe_s1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (acc_rd1),
    .in_data   (mem[s1.address]),
    .out_valid (s1.readdatavalid),
    .out_data  (s1.readdata)
  );

  instrument_mem_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_rd_pipe_s2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (acc_rd2),
    .in_data   (mem[s2.address]),
    .out_valid (s2.readdatavalid),
    .out_data  (s2.readdata)
  );

endmodule
